// File: rtl/frame_buffer.sv
// Double-buffered byte frame store: fills the write bank, swaps it to the reader when a frame completes.
// Read data is registered (one cycle after addr); input has no back-pressure, so bytes are dropped in HUNT/WAIT_SWAP.
module frame_buffer #(
  parameter int FRAME_LEN  = 116,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_sof,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [7:0]            data,
  input  logic                  drop,
  input  logic                  rd_lock,
  output logic                  frame_valid,
  output logic [7:0]            frame_seq,
  output logic [7:0]            discard_cnt
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FRAME_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] LEN  = ADDR_WIDTH'(FRAME_LEN);

  typedef enum logic [1:0] {HUNT, FILL, WAIT_SWAP} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   wr_ptr, ptr_nxt, wr_off;
  logic                    rd_bank, drop_q, abort;
  logic                    wr_en, done, swap, discard;
  logic [7:0]              mem [2][FRAME_LEN];

  assign abort = (drop != drop_q);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = wr_ptr;
    wr_off    = wr_ptr;
    wr_en     = 1'b0;
    done      = 1'b0;
    swap      = 1'b0;
    discard   = 1'b0;
    if (abort) begin
      state_nxt = HUNT;
      ptr_nxt   = '0;
    end else begin
      unique case (state)
        HUNT: begin
          if (in_valid && in_sof) begin
            wr_en     = 1'b1;
            wr_off    = '0;
            ptr_nxt   = ADDR_WIDTH'(1);
            state_nxt = FILL;
            done      = (LAST == '0);
          end
        end
        FILL: begin
          if (in_valid) begin
            wr_en = 1'b1;
            // A byte landing on the last offset completes the frame even if it carries sof
            if (wr_ptr == LAST) begin
              done = 1'b1;
            end else if (in_sof) begin
              wr_off  = '0;
              ptr_nxt = ADDR_WIDTH'(1);
            end else begin
              ptr_nxt = wr_ptr + 1'b1;
            end
          end
        end
        WAIT_SWAP: begin
          discard = in_valid;
          if (!rd_lock) begin
            swap      = 1'b1;
            state_nxt = HUNT;
          end
        end
        default: state_nxt = HUNT;
      endcase
      if (done) begin
        ptr_nxt = '0;
        if (rd_lock) begin
          state_nxt = WAIT_SWAP;
        end else begin
          swap      = 1'b1;
          state_nxt = HUNT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      wr_ptr      <= '0;
      rd_bank     <= 1'b0;
      frame_valid <= 1'b0;
      frame_seq   <= 8'h00;
      discard_cnt <= 8'h00;
      data        <= 8'h00;
      drop_q      <= drop;
    end else begin
      state  <= state_nxt;
      wr_ptr <= ptr_nxt;
      drop_q <= drop;
      if (swap) begin
        rd_bank     <= ~rd_bank;
        frame_valid <= 1'b1;
        frame_seq   <= frame_seq + 8'd1;
      end
      if (discard && discard_cnt != 8'hFF)
        discard_cnt <= discard_cnt + 8'd1;
      // Uses the pre-swap bank on a swap edge
      data <= (addr < LEN) ? mem[rd_bank][addr[IDX_W-1:0]] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en)
      mem[~rd_bank][wr_off[IDX_W-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer: read-back table plus hand sequences for lock, restart, drop, wrap, saturation, reset.
module tb_frame_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sof;
  logic [7:0] addr;
  logic [7:0] data;
  logic       drop;
  logic       rd_lock;
  logic       frame_valid;
  logic [7:0] frame_seq;
  logic [7:0] discard_cnt;

  int total = 0;
  int bad   = 0;

  frame_buffer #(.FRAME_LEN(116), .ADDR_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_sof      (in_sof),
    .addr        (addr),
    .data        (data),
    .drop        (drop),
    .rd_lock     (rd_lock),
    .frame_valid (frame_valid),
    .frame_seq   (frame_seq),
    .discard_cnt (discard_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] exp;
  } rd_vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_seq(input int n, input logic [7:0] base, input logic [7:0] xr,
                          input logic sof_first);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = (8'(i) + base) ^ xr;
      in_sof   = sof_first && (i == 0);
      tick();
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
    addr = a;
    tick();
    chk(nm, data, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rd_vec_t tbl[6];
    tbl[0] = '{8'h10, 8'h10};
    tbl[1] = '{8'h00, 8'h00};
    tbl[2] = '{8'h73, 8'h73};
    tbl[3] = '{8'h74, 8'h00};
    tbl[4] = '{8'hFF, 8'h00};
    tbl[5] = '{8'h41, 8'h41};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_sof = 1'b0;
    addr = 8'h00; drop = 1'b0; rd_lock = 1'b0;
    tick(); tick();
    chk("rst_data", data, 8'h00);
    chk("rst_valid", frame_valid, 1'b0);
    chk("rst_seq", frame_seq, 8'h00);
    chk("rst_discard", discard_cnt, 8'h00);
    rst = 1'b0;

    // First frame 0x00..0x73
    send_seq(115, 8'h00, 8'h00, 1'b1);
    chk("pre_last_valid", frame_valid, 1'b0);
    send_byte(8'h73, 1'b0);
    chk("first_valid", frame_valid, 1'b1);
    chk("first_seq", frame_seq, 8'h01);
    for (int k = 0; k < 6; k++)
      rd(tbl[k].a, tbl[k].exp, $sformatf("tbl_rd%0d", k));

    // Locked completion, discards, then release with a read on the swap edge
    rd_lock = 1'b1;
    send_seq(116, 8'h80, 8'h00, 1'b1);
    chk("lock_seq", frame_seq, 8'h01);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    chk("lock_discard", discard_cnt, 8'h05);
    rd(8'h10, 8'h10, "lock_old_rd");
    addr = 8'h10;
    rd_lock = 1'b0;
    tick();
    chk("release_seq", frame_seq, 8'h02);
    chk("swap_edge_rd", data, 8'h10);
    tick();
    chk("post_swap_rd", data, 8'h90);
    rd(8'h00, 8'h80, "new_rd0");

    // sof restart mid-frame
    send_seq(50, 8'h20, 8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_seq(114, 8'h30, 8'h00, 1'b0);
    chk("restart_no_early", frame_seq, 8'h02);
    send_byte(8'hA2, 1'b0);
    chk("restart_seq", frame_seq, 8'h03);
    rd(8'h00, 8'hAA, "restart_rd0");
    rd(8'h01, 8'h30, "restart_rd1");
    rd(8'h73, 8'hA2, "restart_rd115");

    // drop toggle mid-frame, then a full frame
    send_seq(60, 8'h50, 8'h00, 1'b1);
    in_valid = 1'b1; in_data = 8'hEE; in_sof = 1'b0; drop = ~drop;
    tick();
    in_valid = 1'b0;
    rd(8'h00, 8'hAA, "drop_old_rd");
    chk("drop_seq", frame_seq, 8'h03);
    send_seq(116, 8'h00, 8'h5A, 1'b1);
    chk("after_drop_seq", frame_seq, 8'h04);
    rd(8'h00, 8'h5A, "after_drop_rd0");
    rd(8'h05, 8'h5F, "after_drop_rd5");

    // drop on the completing byte
    send_seq(115, 8'h10, 8'h00, 1'b1);
    in_valid = 1'b1; in_data = 8'h99; in_sof = 1'b0; drop = ~drop;
    tick();
    in_valid = 1'b0;
    chk("drop_last_seq", frame_seq, 8'h04);
    send_seq(116, 8'h40, 8'h00, 1'b0);
    chk("hunt_ignores", frame_seq, 8'h04);
    send_seq(116, 8'h00, 8'hA5, 1'b1);
    chk("hunt_then_frame", frame_seq, 8'h05);
    rd(8'h02, 8'hA7, "hunt_frame_rd2");

    // frame_seq wrap
    for (int k = 0; k < 250; k++)
      send_seq(116, 8'(k), 8'h00, 1'b1);
    chk("seq_ff", frame_seq, 8'hFF);
    send_seq(116, 8'h00, 8'h00, 1'b1);
    chk("seq_wrap", frame_seq, 8'h00);
    chk("wrap_valid", frame_valid, 1'b1);

    // rd_lock raised with the completing byte, then discard saturation
    send_seq(115, 8'h00, 8'h00, 1'b1);
    rd_lock = 1'b1;
    send_byte(8'h77, 1'b0);
    chk("lock_at_done", frame_seq, 8'h00);
    send_seq(240, 8'h00, 8'h00, 1'b0);
    chk("discard_245", discard_cnt, 8'd245);
    send_seq(60, 8'h00, 8'h00, 1'b0);
    chk("discard_sat", discard_cnt, 8'hFF);
    // abort and release together: frame is lost
    rd_lock = 1'b0;
    drop = ~drop;
    tick();
    chk("abort_release", frame_seq, 8'h00);
    tick();
    chk("abort_no_late", frame_seq, 8'h00);
    chk("discard_hold", discard_cnt, 8'hFF);

    // reset mid-frame
    send_seq(30, 8'h00, 8'h00, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", frame_valid, 1'b0);
    chk("mid_rst_seq", frame_seq, 8'h00);
    chk("mid_rst_discard", discard_cnt, 8'h00);
    chk("mid_rst_data", data, 8'h00);
    send_seq(116, 8'h60, 8'h00, 1'b1);
    chk("post_rst_seq", frame_seq, 8'h01);
    rd(8'h10, 8'h70, "post_rst_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
